// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle RV32I core: word RAM plus a small MMIO bank.
// Optional cycle counter enabled by defining DMEM_CYCLE_CNT_EN.
module dmem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  bus_err
);

  localparam int                    AW        = $clog2(DEPTH);
  localparam logic [DATA_WIDTH-1:0] RAM_BYTES = DATA_WIDTH'(DEPTH * 4);
  localparam logic [DATA_WIDTH-1:0] ID_VALUE  = DATA_WIDTH'(32'h5256_3332);

  localparam logic [1:0] REG_GPIO   = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  logic                  access;
  logic                  is_mmio;
  logic                  unaligned;
  logic                  beyond;
  logic                  err_mis;
  logic                  err_oor;
  logic                  legal_wr;
  logic [1:0]            reg_sel;
  logic [AW-1:0]         word_idx;
  logic                  ram_we;
  logic                  gpio_we;
  logic                  status_we;
  logic [1:0]            status;
  logic [1:0]            status_set;
  logic [1:0]            status_clr;
  logic [1:0]            status_next;
  logic [DATA_WIDTH-1:0] cycle_rd;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Address decode and error classification
  assign access    = mem_read | mem_write;
  assign is_mmio   = (addr[DATA_WIDTH-1] == MMIO_BASE[DATA_WIDTH-1]);
  assign unaligned = (addr[1:0] != 2'b00);
  assign beyond    = !is_mmio && (addr >= RAM_BYTES);
  assign err_mis   = access & unaligned;
  assign err_oor   = access & beyond;
  assign legal_wr  = mem_write & ~unaligned & ~beyond;
  assign reg_sel   = addr[3:2];
  assign word_idx  = addr[AW+1:2];

  assign ram_we    = legal_wr & ~is_mmio;
  assign gpio_we   = legal_wr & is_mmio & (reg_sel == REG_GPIO);
  assign status_we = legal_wr & is_mmio & (reg_sel == REG_STATUS);

  // Set takes priority over a write-one-to-clear on the same bit.
  assign status_set  = {err_oor, err_mis};
  assign status_clr  = status_we ? write_data[1:0] : 2'b00;
  assign status_next = (status & ~status_clr) | status_set;

  // RAM is data storage: no reset, but a store coinciding with reset is dropped
  always_ff @(posedge CLK) begin
    if (ram_we && !RST) begin
      ram[word_idx] <= write_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gpio_out <= '0;
      status   <= 2'b00;
      bus_err  <= 1'b0;
    end else begin
      if (gpio_we) begin
        gpio_out <= write_data;
      end
      status  <= status_next;
      bus_err <= |status_next;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  logic                  cycle_we;
  logic [DATA_WIDTH-1:0] cycle_cnt;

  assign cycle_we = legal_wr & is_mmio & (reg_sel == REG_CYCLE);

  // A software load overrides the free-running increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_cnt <= '0;
    end else if (cycle_we) begin
      cycle_cnt <= write_data;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  assign cycle_rd = cycle_cnt;
`else
  assign cycle_rd = '0;
`endif

  // Combinational load path; illegal addresses read as zero
  always_comb begin
    read_data = '0;
    if (!unaligned && !beyond) begin
      if (is_mmio) begin
        case (reg_sel)
          REG_GPIO:   read_data = gpio_out;
          REG_CYCLE:  read_data = cycle_rd;
          REG_STATUS: read_data = {{(DATA_WIDTH-2){1'b0}}, status};
          REG_ID:     read_data = ID_VALUE;
          default:    read_data = '0;
        endcase
      end else begin
        read_data = ram[word_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; counter checks follow DMEM_CYCLE_CNT_EN.
module tb_dmem_responder;

  logic        CLK;
  logic        RST;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic        bus_err;

  int passed = 0;
  int total  = 0;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH(64), .MMIO_BASE(32'h8000_0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .gpio_out   (gpio_out),
    .bus_err    (bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    addr       = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge CLK);
    #1;
    mem_write  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    #1;
    d        = read_data;
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    RST = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = '0; write_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (gpio_out !== 32'h0) $display("FAIL reset_gpio: got %h expected %h", gpio_out, 32'h0); else passed++;
    total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err: got %b expected %b", bus_err, 1'b0); else passed++;
    @(negedge CLK);
    RST = 1'b0;
    do_read(32'h8000_0008, v);
    total++; if (v !== 32'h0) $display("FAIL reset_status: got %h expected %h", v, 32'h0); else passed++;
  endtask

  task automatic test_store_load();
    logic [31:0] v;
    do_write(32'h14, 32'h1111_1111);
    do_write(32'h10, 32'hDEAD_BEEF);
    do_read(32'h10, v);
    total++; if (v !== 32'hDEAD_BEEF) $display("FAIL store_load_10: got %h expected %h", v, 32'hDEAD_BEEF); else passed++;
    do_read(32'h14, v);
    total++; if (v !== 32'h1111_1111) $display("FAIL store_load_14: got %h expected %h", v, 32'h1111_1111); else passed++;
    do_write(32'hFC, 32'h0BAD_F00D);
    do_read(32'hFC, v);
    total++; if (v !== 32'h0BAD_F00D) $display("FAIL store_load_top: got %h expected %h", v, 32'h0BAD_F00D); else passed++;
  endtask

  task automatic test_gpio();
    logic [31:0] v;
    do_write(32'h8000_0000, 32'h0000_00A5);
    total++; if (gpio_out !== 32'hA5) $display("FAIL gpio_out: got %h expected %h", gpio_out, 32'hA5); else passed++;
    do_read(32'h8000_0000, v);
    total++; if (v !== 32'hA5) $display("FAIL gpio_read: got %h expected %h", v, 32'hA5); else passed++;
    do_read(32'h8123_4560, v);
    total++; if (v !== 32'hA5) $display("FAIL gpio_alias: got %h expected %h", v, 32'hA5); else passed++;
    #1;
    RST = 1'b1;
    #1;
    total++; if (gpio_out !== 32'h0) $display("FAIL gpio_async_reset: got %h expected %h", gpio_out, 32'h0); else passed++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [31:0] v;
    do_write(32'h20, 32'hCAFE_0000);
    do_write(32'h22, 32'h0000_1234);
    total++; if (bus_err !== 1'b1) $display("FAIL mis_bus_err: got %b expected %b", bus_err, 1'b1); else passed++;
    do_read(32'h20, v);
    total++; if (v !== 32'hCAFE_0000) $display("FAIL mis_word_kept: got %h expected %h", v, 32'hCAFE_0000); else passed++;
    do_read(32'h8000_0008, v);
    total++; if (v !== 32'h1) $display("FAIL mis_status: got %h expected %h", v, 32'h1); else passed++;
    do_write(32'h8000_0008, 32'h1);
    total++; if (bus_err !== 1'b0) $display("FAIL mis_clear_bus_err: got %b expected %b", bus_err, 1'b0); else passed++;
    do_read(32'h8000_0008, v);
    total++; if (v !== 32'h0) $display("FAIL mis_clear_status: got %h expected %h", v, 32'h0); else passed++;
    do_write(32'h8000_0001, 32'hFF);
    total++; if (gpio_out !== 32'h0) $display("FAIL mis_gpio_suppressed: got %h expected %h", gpio_out, 32'h0); else passed++;
    do_read(32'h8000_0002, v);
    total++; if (v !== 32'h0) $display("FAIL mis_read_zero: got %h expected %h", v, 32'h0); else passed++;
    do_write(32'h8000_0008, 32'h3);
    total++; if (bus_err !== 1'b0) $display("FAIL mis_clear2: got %b expected %b", bus_err, 1'b0); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] v;
    @(negedge CLK);
    addr = 32'h100; mem_read = 1'b0;
    #1;
    total++; if (read_data !== 32'h0) $display("FAIL oor_idle_read: got %h expected %h", read_data, 32'h0); else passed++;
    @(posedge CLK);
    #1;
    total++; if (bus_err !== 1'b0) $display("FAIL oor_idle_no_err: got %b expected %b", bus_err, 1'b0); else passed++;
    @(negedge CLK);
    addr = 32'h100; mem_read = 1'b1;
    #1;
    total++; if (read_data !== 32'h0) $display("FAIL oor_read_zero: got %h expected %h", read_data, 32'h0); else passed++;
    @(posedge CLK);
    #1;
    mem_read = 1'b0;
    total++; if (bus_err !== 1'b1) $display("FAIL oor_bus_err: got %b expected %b", bus_err, 1'b1); else passed++;
    do_read(32'h8000_0008, v);
    total++; if (v !== 32'h2) $display("FAIL oor_status: got %h expected %h", v, 32'h2); else passed++;
    do_write(32'h8000_0008, 32'h2);
    total++; if (bus_err !== 1'b0) $display("FAIL oor_clear: got %b expected %b", bus_err, 1'b0); else passed++;
  endtask

  task automatic test_id();
    logic [31:0] v;
    do_read(32'h8000_000C, v);
    total++; if (v !== 32'h5256_3332) $display("FAIL id_read: got %h expected %h", v, 32'h5256_3332); else passed++;
    do_write(32'h8000_000C, 32'h0);
    do_read(32'h8000_0F0C, v);
    total++; if (v !== 32'h5256_3332) $display("FAIL id_after_write: got %h expected %h", v, 32'h5256_3332); else passed++;
    total++; if (bus_err !== 1'b0) $display("FAIL id_write_no_err: got %b expected %b", bus_err, 1'b0); else passed++;
  endtask

  task automatic test_cycle();
    logic [31:0] v;
    logic [31:0] e0, e1, e2;
`ifdef DMEM_CYCLE_CNT_EN
    e0 = 32'hFFFF_FFFE; e1 = 32'hFFFF_FFFF; e2 = 32'h0;
`else
    e0 = 32'h0; e1 = 32'h0; e2 = 32'h0;
`endif
    do_write(32'h8000_0004, 32'hFFFF_FFFE);
    do_read(32'h8000_0004, v);
    total++; if (v !== e0) $display("FAIL cycle_load: got %h expected %h", v, e0); else passed++;
    @(posedge CLK);
    #1;
    do_read(32'h8000_0004, v);
    total++; if (v !== e1) $display("FAIL cycle_inc: got %h expected %h", v, e1); else passed++;
    @(posedge CLK);
    #1;
    do_read(32'h8000_0004, v);
    total++; if (v !== e2) $display("FAIL cycle_wrap: got %h expected %h", v, e2); else passed++;
    total++; if (bus_err !== 1'b0) $display("FAIL cycle_no_err: got %b expected %b", bus_err, 1'b0); else passed++;
  endtask

  task automatic test_read_during_write();
    do_write(32'h0, 32'h55);
    @(negedge CLK);
    addr = 32'h0; write_data = 32'h1; mem_write = 1'b1; mem_read = 1'b1;
    #1;
    total++; if (read_data !== 32'h55) $display("FAIL rdw_before: got %h expected %h", read_data, 32'h55); else passed++;
    @(posedge CLK);
    #1;
    total++; if (read_data !== 32'h1) $display("FAIL rdw_after: got %h expected %h", read_data, 32'h1); else passed++;
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_reset_drops_store();
    logic [31:0] v;
    do_write(32'h30, 32'h77);
    do_write(32'h8000_0000, 32'h3C);
    @(negedge CLK);
    addr = 32'h30; write_data = 32'h99; mem_write = 1'b1; RST = 1'b1;
    @(posedge CLK);
    #1;
    mem_write = 1'b0;
    total++; if (gpio_out !== 32'h0) $display("FAIL rst_gpio: got %h expected %h", gpio_out, 32'h0); else passed++;
    @(negedge CLK);
    RST = 1'b0;
    do_read(32'h30, v);
    total++; if (v !== 32'h77) $display("FAIL rst_store_dropped: got %h expected %h", v, 32'h77); else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_gpio();
    test_misaligned();
    test_out_of_range();
    test_id();
    test_cycle();
    test_read_during_write();
    test_reset_drops_store();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
